// File: rtl/uart_prog_loader.sv
`default_nettype none
// ============================================================================
// Module  : uart_prog_loader
// Brief   : UART-framed, checksummed program loader with a registered fetch port
// Revision: 1.0 - initial release
// ============================================================================
module uart_prog_loader #(
  parameter int CLKS_PER_BIT    = 434,
  parameter int ADDR_W          = 8,
  parameter int WORD_BYTES      = 2,
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    rx,
  input  logic                    button,
  input  logic [ADDR_W-1:0]       addr_pc,
  output logic [8*WORD_BYTES-1:0] data_out,
  output logic                    mode,
  output logic                    load_done,
  output logic                    load_err,
  output logic [ADDR_W:0]         word_count
);
  localparam int DEPTH  = 1 << ADDR_W;
  localparam int DATA_W = 8 * WORD_BYTES;
  localparam int LEN_W  = ADDR_W + 1;
  localparam int CNT_W  = $clog2(CLKS_PER_BIT);
  localparam int BI_W   = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;
  localparam int DB_W   = $clog2(DEBOUNCE_CYCLES + 1);

  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [BI_W-1:0]  BYTE_LAST = BI_W'(WORD_BYTES - 1);
  localparam logic [DB_W-1:0]  DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);

  localparam logic [2:0] RX_IDLE  = 3'd0;
  localparam logic [2:0] RX_START = 3'd1;
  localparam logic [2:0] RX_DATA  = 3'd2;
  localparam logic [2:0] RX_STOP  = 3'd3;
  localparam logic [2:0] RX_BREAK = 3'd4;

  localparam logic [1:0] FR_HDR  = 2'd0;
  localparam logic [1:0] FR_LEN  = 2'd1;
  localparam logic [1:0] FR_DATA = 2'd2;
  localparam logic [1:0] FR_CHK  = 2'd3;

  logic              rx_s1_q, rx_s2_q, btn_s1_q, btn_s2_q;
  logic [2:0]        rx_state_q, rx_state_d;
  logic [CNT_W-1:0]  rx_cnt_q, rx_cnt_d;
  logic [2:0]        rx_bit_q, rx_bit_d;
  logic [7:0]        rx_shift_q, rx_shift_d;
  logic              byte_vld_q, byte_vld_d, frame_err_q, frame_err_d;
  logic [DB_W-1:0]   db_cnt_q, db_cnt_d;
  logic              db_state_q, db_state_d, toggle;
  logic [1:0]        fr_state_q, fr_state_d;
  logic [LEN_W-1:0]  len_q, len_d, words_q, words_d, words_inc;
  logic [BI_W-1:0]   bidx_q, bidx_d;
  logic [DATA_W-1:0] wbuf_q, wbuf_d, word_next, data_out_q, data_out_d;
  logic [7:0]        sum_q, sum_d, sum_next;
  logic              mode_q, mode_d, done_q, done_d, err_q, err_d;
  logic [ADDR_W:0]   wcount_q, wcount_d;
  logic              mem_we, chk_good;
  logic [DATA_W-1:0] mem [DEPTH];

  // UART receiver; RX_BREAK waits out a low stop bit so it is not taken as a new start.
  always_comb begin
    rx_state_d  = rx_state_q;
    rx_cnt_d    = rx_cnt_q;
    rx_bit_d    = rx_bit_q;
    rx_shift_d  = rx_shift_q;
    byte_vld_d  = 1'b0;
    frame_err_d = 1'b0;
    case (rx_state_q)
      RX_IDLE: if (!rx_s2_q) begin
        rx_state_d = RX_START;
        rx_cnt_d   = '0;
      end
      RX_START: if (rx_cnt_q == HALF_LAST) begin
        rx_cnt_d   = '0;
        rx_bit_d   = '0;
        rx_state_d = rx_s2_q ? RX_IDLE : RX_DATA;
      end else rx_cnt_d = rx_cnt_q + 1'b1;
      RX_DATA: if (rx_cnt_q == BIT_LAST) begin
        rx_cnt_d   = '0;
        rx_shift_d = {rx_s2_q, rx_shift_q[7:1]};
        rx_bit_d   = rx_bit_q + 1'b1;
        if (rx_bit_q == 3'd7) rx_state_d = RX_STOP;
      end else rx_cnt_d = rx_cnt_q + 1'b1;
      RX_STOP: if (rx_cnt_q == BIT_LAST) begin
        rx_cnt_d    = '0;
        byte_vld_d  = rx_s2_q;
        frame_err_d = !rx_s2_q;
        rx_state_d  = rx_s2_q ? RX_IDLE : RX_BREAK;
      end else rx_cnt_d = rx_cnt_q + 1'b1;
      RX_BREAK: if (rx_s2_q) rx_state_d = RX_IDLE;
      default: rx_state_d = RX_IDLE;
    endcase
  end

  always_comb begin
    db_cnt_d   = '0;
    db_state_d = db_state_q;
    toggle     = 1'b0;
    if (btn_s2_q != db_state_q) begin
      if (db_cnt_q == DB_LAST) begin
        db_state_d = btn_s2_q;
        toggle     = !btn_s2_q;
      end else db_cnt_d = db_cnt_q + 1'b1;
    end
  end

  always_comb begin
    fr_state_d = fr_state_q;
    len_d      = len_q;
    words_d    = words_q;
    bidx_d     = bidx_q;
    wbuf_d     = wbuf_q;
    sum_d      = sum_q;
    mode_d     = mode_q;
    done_d     = done_q;
    err_d      = err_q;
    wcount_d   = wcount_q;
    mem_we     = 1'b0;
    chk_good   = 1'b0;
    word_next  = (wbuf_q << 8) | DATA_W'(rx_shift_q);
    words_inc  = words_q + 1'b1;
    sum_next   = sum_q + rx_shift_q;
    if (!mode_q) begin
      if (frame_err_q) begin
        if (fr_state_q != FR_HDR) begin
          err_d  = 1'b1;
          done_d = 1'b0;
        end
        fr_state_d = FR_HDR;
      end else if (byte_vld_q) begin
        case (fr_state_q)
          FR_HDR: if (rx_shift_q == 8'hA5) begin
            fr_state_d = FR_LEN;
            done_d     = 1'b0;
            err_d      = 1'b0;
            sum_d      = '0;
          end
          FR_LEN: if (rx_shift_q == 8'h00 || 32'(rx_shift_q) > DEPTH) begin
            err_d      = 1'b1;
            fr_state_d = FR_HDR;
          end else begin
            len_d      = LEN_W'(rx_shift_q);
            words_d    = '0;
            bidx_d     = '0;
            fr_state_d = FR_DATA;
          end
          FR_DATA: begin
            sum_d  = sum_next;
            wbuf_d = word_next;
            if (bidx_q == BYTE_LAST) begin
              mem_we  = 1'b1;
              bidx_d  = '0;
              words_d = words_inc;
              if (words_inc == len_q) fr_state_d = FR_CHK;
            end else bidx_d = bidx_q + 1'b1;
          end
          default: begin
            fr_state_d = FR_HDR;
            if (sum_next == 8'h00) begin
              chk_good = 1'b1;
              done_d   = 1'b1;
              err_d    = 1'b0;
              wcount_d = len_q;
              mode_d   = 1'b1;
            end else begin
              err_d  = 1'b1;
              done_d = 1'b0;
            end
          end
        endcase
      end
    end
    // A successful checksum claims the mode change; a coincident press is dropped.
    if (toggle && !chk_good) begin
      mode_d     = !mode_q;
      fr_state_d = FR_HDR;
    end
  end

  assign data_out_d = mode_q ? mem[addr_pc] : '0;

  always_ff @(posedge clk) begin
    if (mem_we) mem[words_q[ADDR_W-1:0]] <= word_next;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rx_s1_q     <= 1'b1;
      rx_s2_q     <= 1'b1;
      btn_s1_q    <= 1'b1;
      btn_s2_q    <= 1'b1;
      rx_state_q  <= RX_IDLE;
      rx_cnt_q    <= '0;
      rx_bit_q    <= '0;
      rx_shift_q  <= '0;
      byte_vld_q  <= 1'b0;
      frame_err_q <= 1'b0;
      db_cnt_q    <= '0;
      db_state_q  <= 1'b1;
      fr_state_q  <= FR_HDR;
      len_q       <= '0;
      words_q     <= '0;
      bidx_q      <= '0;
      wbuf_q      <= '0;
      sum_q       <= '0;
      mode_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      wcount_q    <= '0;
      data_out_q  <= '0;
    end else begin
      rx_s1_q     <= rx;
      rx_s2_q     <= rx_s1_q;
      btn_s1_q    <= button;
      btn_s2_q    <= btn_s1_q;
      rx_state_q  <= rx_state_d;
      rx_cnt_q    <= rx_cnt_d;
      rx_bit_q    <= rx_bit_d;
      rx_shift_q  <= rx_shift_d;
      byte_vld_q  <= byte_vld_d;
      frame_err_q <= frame_err_d;
      db_cnt_q    <= db_cnt_d;
      db_state_q  <= db_state_d;
      fr_state_q  <= fr_state_d;
      len_q       <= len_d;
      words_q     <= words_d;
      bidx_q      <= bidx_d;
      wbuf_q      <= wbuf_d;
      sum_q       <= sum_d;
      mode_q      <= mode_d;
      done_q      <= done_d;
      err_q       <= err_d;
      wcount_q    <= wcount_d;
      data_out_q  <= data_out_d;
    end
  end

  assign data_out   = data_out_q;
  assign mode       = mode_q;
  assign load_done  = done_q;
  assign load_err   = err_q;
  assign word_count = wcount_q;
endmodule
`default_nettype wire
